// File: rtl/next_line_prefetcher_pkg.sv
// Shared types and helpers for the next-line prefetch engine: FSM state
// encoding, line geometry, and the next-line address computation.
package pf_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } pf_state_t;

    localparam int LINE_BYTES  = 32;
    localparam int OFFSET_BITS = 5;

    // Returns {valid, next_line_address}. The line after the topmost line
    // would wrap to address zero, which is never a useful prefetch, so that
    // case comes back with valid cleared.
    function automatic logic [32:0] next_line(input logic [31:0] addr);
        logic [31-OFFSET_BITS:0] base;
        base      = addr[31:OFFSET_BITS];
        next_line = {~&base, base + 27'd1, {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/next_line_prefetcher.sv
// Next-line prefetcher: on a demand-miss trigger it fetches the following
// 32-byte line through the arbiter's prefetch port, then offers that line to
// the prefetch cache until it is acknowledged. One pending trigger is queued
// while busy, and lines already in flight, queued or just fetched are not
// requested again.
module next_line_prefetcher
    import pf_types::*;
#(
    parameter int s_offset = 5,
    parameter int s_line   = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pf_enable,
    input  logic              trigger_valid,
    input  logic [31:0]       trigger_address,
    input  logic              pf_flush,
    output logic              pf_pmem_read,
    output logic [31:0]       pf_pmem_address,
    input  logic [s_line-1:0] pf_pmem_rdata,
    input  logic              pf_pmem_resp,
    output logic              prefetch_ready,
    output logic [31:0]       pf_cline_address,
    output logic [s_line-1:0] prefetch_rdata,
    input  logic              pf_ack
);

    pf_state_t         state;
    logic [31:0]       target;
    logic [s_line-1:0] buffer;
    logic              pend_valid;
    logic [31:0]       pend_addr;
    logic              last_valid;
    logic [31:0]       last_addr;
    logic              discard;

    logic [32:0]       nl;
    logic              next_ok;
    logic [31:0]       next_addr;
    logic              dup;
    logic              accept;

    // Decide whether this cycle's trigger produces a new, non-duplicate line.
    always_comb begin
        nl        = next_line(trigger_address);
        next_ok   = nl[32];
        next_addr = nl[31:0];
        dup       = ((state != IDLE) && (next_addr == target)) ||
                    (pend_valid && (next_addr == pend_addr)) ||
                    (last_valid && (next_addr == last_addr));
        accept    = pf_enable && trigger_valid && !pf_flush && next_ok && !dup;
    end

    // Fetch/hold state machine plus the pending slot and recent-line filter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            target     <= '0;
            buffer     <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            last_valid <= 1'b0;
            last_addr  <= '0;
            discard    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pend_valid && !pf_flush) begin
                        target <= pend_addr;
                        state  <= FETCH;
                    end else if (accept) begin
                        target <= next_addr;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    if (pf_pmem_resp) begin
                        buffer     <= pf_pmem_rdata;
                        last_addr  <= target;
                        last_valid <= 1'b1;
                        discard    <= 1'b0;
                        state      <= (discard || pf_flush) ? IDLE : HOLD;
                    end else if (pf_flush) begin
                        discard <= 1'b1;
                    end
                end
                HOLD: begin
                    if (pf_flush || pf_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A trigger that cannot start right away lands in the pending
            // slot; the newest one wins. The slot empties when IDLE drains it.
            if (pf_flush) begin
                pend_valid <= 1'b0;
            end else if (accept && ((state != IDLE) || pend_valid)) begin
                pend_addr  <= next_addr;
                pend_valid <= 1'b1;
            end else if ((state == IDLE) && pend_valid) begin
                pend_valid <= 1'b0;
            end

            // Flush forgets the recent line even if a response lands now.
            if (pf_flush) begin
                last_valid <= 1'b0;
            end
        end
    end

    assign pf_pmem_read     = (state == FETCH);
    assign pf_pmem_address  = {target[31:s_offset], {s_offset{1'b0}}};
    assign prefetch_ready   = (state == HOLD);
    assign pf_cline_address = {target[31:s_offset], {s_offset{1'b0}}};
    assign prefetch_rdata   = buffer;

endmodule

// File: doc/next_line_prefetcher.md
Name: next_line_prefetcher

Overview:
- Next-line prefetch engine that feeds the prefetch cache.
- On each demand-miss trigger from the cache controller, it computes the following 32-byte line address and reads that line from physical memory through the arbiter's prefetch port.
- It holds the fetched line and offers it to the cache with prefetch_ready / pf_cline_address / prefetch_rdata until the cache acknowledges.
- It keeps one pending trigger slot and suppresses duplicate fetches.

Parameters:
- s_offset, 5, byte-offset bits per line (line = 32 bytes).
- s_line, 256, line width in bits (8 * 2**s_offset).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pf_enable  in  1  triggers are ignored when 0.
- trigger_valid  in  1  one-cycle pulse from the cache controller on a demand miss.
- trigger_address  in  32  demand miss address (any byte offset).
- pf_flush  in  1  discards the held line and the pending trigger.
- pf_pmem_read  out  1  read request to the arbiter's prefetch port.
- pf_pmem_address  out  32  line-aligned fetch address.
- pf_pmem_rdata  in  256  line returned by the arbiter.
- pf_pmem_resp  in  1  one-cycle completion pulse from the arbiter.
- prefetch_ready  out  1  held line is available to the cache.
- pf_cline_address  out  32  line-aligned address of the held line.
- prefetch_rdata  out  256  held line data.
- pf_ack  in  1  cache has installed or declined the held line.

Behaviour:
- Next-line computation:
  - base = trigger_address[31:5]; next = {base + 1, 5'b0}.
  - If base is all ones, there is no wrap to 0x00000000: the trigger is dropped.
- Registers: state, target[31:0], buffer[255:0], pend_valid, pend_addr[31:0], last_valid, last_addr[31:0], discard.
- Reset: state=IDLE, every register cleared, all outputs 0.
- Duplicate rule: a computed next is dropped if it equals target while state != IDLE, or equals pend_addr while pend_valid, or equals last_addr while last_valid.
- Triggers are accepted only when pf_enable=1 and the duplicate rule passes.
- IDLE:
  - If pend_valid: target <= pend_addr, clear pend_valid, go to FETCH.
  - Else if a trigger is accepted: target <= next, go to FETCH.
  - The request is asserted in the cycle after the trigger; trigger-to-pf_pmem_read latency is 1 cycle.
  - If pend_valid and a trigger are both present, the pending entry is fetched and the trigger goes into the pending slot.
- FETCH:
  - pf_pmem_read=1 and pf_pmem_address=target, held stable until pf_pmem_resp.
  - On pf_pmem_resp: buffer <= pf_pmem_rdata; last_addr <= target; last_valid <= 1.
  - If discard=1: clear discard, go to IDLE. Otherwise go to HOLD.
- HOLD:
  - prefetch_ready=1, pf_cline_address=target, prefetch_rdata=buffer.
  - On pf_ack: go to IDLE, with prefetch_ready low the next cycle.
- Accepted triggers in FETCH or HOLD write pend_addr and set pend_valid. A newer trigger overwrites an older pending entry.
- Outputs outside their states:
  - pf_pmem_read and prefetch_ready are 0.
  - pf_cline_address and prefetch_rdata are don't-care, but driven from the registers (no X).
- pf_flush:
  - Clears pend_valid and last_valid.
  - In HOLD: go to IDLE at once; pf_ack in the same cycle is ignored.
  - In FETCH: the memory transaction completes (the request stays asserted) with discard=1, so the line is never presented.
  - A trigger in the same cycle as pf_flush is dropped.
- pf_enable deassertion does not cancel an in-flight fetch or a held line.
- pf_pmem_resp outside FETCH and pf_ack outside HOLD are ignored.
- Reset mid-FETCH abandons the transaction; the arbiter is reset by the same rst.

Decomposition:
- Package pf_types:
  - enum pf_state_t {IDLE, FETCH, HOLD}.
  - constants LINE_BYTES=32, OFFSET_BITS=5.
  - function next_line(addr) returning {valid, addr}.
- Single module. The 256-bit buffer is a plain register, with no sub-module.

Test Plan:
- Basic fetch:
  - Stimulus: trigger 0x00001234.
  - Required: next cycle pf_pmem_read=1 with address 0x00001240. Hold resp 3 cycles, pulse resp with data D. Then prefetch_ready=1, pf_cline_address=0x00001240, rdata=D. pf_ack, then ready=0 next cycle.
- Pending slot:
  - Stimulus: in FETCH for 0x00001240, trigger 0x00002000 then 0x00003000.
  - Required: after ack, one IDLE cycle, then fetch address 0x00003020; 0x00002020 is never requested.
- Duplicates:
  - Stimulus: during FETCH of 0x00001240, trigger 0x00001230; after ack, trigger 0x0000123C.
  - Required: no new request in either case.
- Wrap:
  - Stimulus: trigger 0xFFFFFFE4.
  - Required: no request, state stays IDLE.
- Flush:
  - Stimulus: pf_flush during FETCH, then resp.
  - Required: prefetch_ready never asserts and the state returns to IDLE.
  - Stimulus: pf_flush during HOLD with pf_ack also high.
  - Required: ready=0 next cycle.
- Reset and enable:
  - Stimulus: rst in HOLD.
  - Required: all outputs 0 next cycle.
  - Stimulus: trigger with pf_enable=0.
  - Required: ignored.
